conv_mac_engine: RTL
====================

Name: conv_mac_engine

Overview:
- Parametrised successor to the current 1-D convolution core: computes Z[n] = sum_k X[k]*Y[n-k] over signed operands held in two synchronous-read memories, and writes every output sample to a result memory.
- Adds runtime sizes as ports, a convolution/correlation mode, a wide internal accumulator and a fully pipelined one-MAC-per-cycle datapath.
- Sits behind the IP config/status registers, between the X, Y and Z memory ports.

Parameters:
DATA_WIDTH, 8, signed X/Y sample width
ADDR_WIDTH, 5, X/Y memory address width; Z address is ADDR_WIDTH+1
OUT_WIDTH, 2*DATA_WIDTH, dataZ width
ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH, internal accumulator width (must be >= OUT_WIDTH)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle start pulse; sampled only in IDLE
size_x  in  ADDR_WIDTH  X length, 0..2^ADDR_WIDTH-1
size_y  in  ADDR_WIDTH  Y length
mode  in  1  0 = convolution; 1 = correlation (Y read reversed: index size_y-1-(n-k))
memx_addr  out  ADDR_WIDTH  X read address; data returns next cycle
datax  in  DATA_WIDTH  X read data, signed
memy_addr  out  ADDR_WIDTH  Y read address; data returns next cycle
datay  in  DATA_WIDTH  Y read data, signed
dataz  out  OUT_WIDTH  result sample
memz_addr  out  ADDR_WIDTH+1  result address n
writez  out  1  one-cycle write strobe for dataz/memz_addr
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - All outputs are 0: busy, done, writez, dataz, memz_addr, memx_addr, memy_addr.
  - Reset asserted mid-run aborts the run the next edge; no further writez.
- Latching: size_x, size_y and mode are captured on the start cycle. Later changes have no effect until the next start. start while busy is ignored.
- FSM states:
  - IDLE: on start -> RUN, or -> DONE if size_x==0 or size_y==0 (no writes).
  - RUN: issues one (k, n-k) address pair per cycle with no bubbles.
    - n runs 0..size_x+size_y-2.
    - For each n, k runs max(0, n-size_y+1)..min(n, size_x-1).
    - After the last pair of the last n -> DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 in that cycle -> IDLE.
- Pipeline:
  - Cycle t: addresses issued.
  - Cycle t+1: datax*datay computed at full 2*DATA_WIDTH signed precision, sign-extended to ACC_WIDTH, added to acc. The first product of each n loads acc instead of adding.
  - Cycle t+2, after the last pair for n: writez=1, memz_addr=n, dataz=acc reduced to OUT_WIDTH.
- Timing: with P = size_x*size_y and start in cycle 0:
  - addresses are issued in cycles 1..P;
  - the final writez is in cycle P+2;
  - done is in cycle P+3.
- Output count: exactly size_x+size_y-1 writez pulses per run, in ascending n order. Consecutive outputs may be 1 cycle apart (single-term n).
- Width reduction: dataz is acc[OUT_WIDTH-1:0], two's-complement truncation.
- Address outputs hold their last value between runs. memz_addr, dataz and writez hold 0/last value outside write cycles.

Optional Feature:
- Macro CONV_MAC_SATURATE_EN.
- Defined: dataz is acc clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and a sticky status output sat_flag (1 bit) is added. sat_flag sets when any written sample clamped and clears on start or rst.
- Undefined: truncation as above; no sat_flag port.

Decomposition:
- Package conv_mac_pkg:
  - state_t enum {IDLE, RUN, DRAIN, DONE};
  - mode_t enum {MODE_CONV, MODE_CORR};
  - localparam PIPE_DEPTH = 2.
- Sub-module conv_index_gen: owns the n/k counters, the bounds math, the mode-dependent Y index, and the first/last-term flags. It feeds the MAC pipeline delayed by PIPE_DEPTH.

Test Plan:
- Basic convolution: X={1,2,3}, Y={4,5}, mode=0 -> writez at Z[0..3] = {4,13,22,15}; done at cycle 9; busy high in cycles 1..8.
- Correlation: same data, mode=1 -> Z = {5,14,23,12}.
- Signed operands: X={-128,127}, Y={-128} -> Z = {16384,-16256}.
- Overflow, all 127, size_x=size_y=4:
  - middle output Z[3] = 4*16129 = 64516;
  - without CONV_MAC_SATURATE_EN: dataz = -1020;
  - with it: dataz = 32767 and sat_flag=1.
- Zero size: size_x=0, size_y=3, start -> no writez; done pulses in cycle 1.
- Robustness:
  - start pulsed during RUN is ignored, and the write count stays size_x+size_y-1;
  - rst asserted in cycle 3 of a 3x2 run -> all outputs 0 next cycle, no further writez;
  - a fresh start afterwards yields the correct results.

Source files
------------

// File: rtl/conv_mac_pkg.sv
// ---------------------------------------------------------------------------
// conv_mac_pkg
// Shared types and constants for the conv_mac_engine block.
//   state_t    : control FSM states (IDLE, RUN, DRAIN, DONE)
//   mode_t     : convolution / correlation selector
//   PIPE_DEPTH : cycles from address issue to the accumulator result
// ---------------------------------------------------------------------------
package conv_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_CORR = 1'b1
  } mode_t;

  localparam int PIPE_DEPTH = 2;

endpackage

// File: rtl/conv_mac_engine_if.sv
// ---------------------------------------------------------------------------
// conv_mac_engine_if
// Bundles the control, memory-port and status signals of conv_mac_engine.
//   master : the side driving start/sizes/mode and returning X/Y read data
//   slave  : the engine itself
// Signals:
//   start, size_x, size_y, mode        run control
//   memx_addr/datax, memy_addr/datay   synchronous-read operand memories
//   dataz, memz_addr, writez           result memory write port
//   busy, done                         status
//   sat_flag                           sticky clamp flag (CONV_MAC_SATURATE_EN only)
// ---------------------------------------------------------------------------
interface conv_mac_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] size_x;
  logic [ADDR_WIDTH-1:0] size_y;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] memx_addr;
  logic [DATA_WIDTH-1:0] datax;
  logic [ADDR_WIDTH-1:0] memy_addr;
  logic [DATA_WIDTH-1:0] datay;
  logic [OUT_WIDTH-1:0]  dataz;
  logic [ADDR_WIDTH:0]   memz_addr;
  logic                  writez;
  logic                  busy;
  logic                  done;
`ifdef CONV_MAC_SATURATE_EN
  logic                  sat_flag;
`endif

  modport master (
    output start, size_x, size_y, mode, datax, datay,
`ifdef CONV_MAC_SATURATE_EN
    input  sat_flag,
`endif
    input  memx_addr, memy_addr, dataz, memz_addr, writez, busy, done
  );

  modport slave (
    input  start, size_x, size_y, mode, datax, datay,
`ifdef CONV_MAC_SATURATE_EN
    output sat_flag,
`endif
    output memx_addr, memy_addr, dataz, memz_addr, writez, busy, done
  );

endinterface

// File: rtl/conv_index_gen.sv
// ---------------------------------------------------------------------------
// conv_index_gen
// Walks the (n, k) index space of a 1-D convolution, one pair per cycle:
//   n = 0 .. size_x+size_y-2,  k = max(0, n-size_y+1) .. min(n, size_x-1)
// and produces registered X/Y read addresses with per-pair tags.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load_i                accepted start: latch sizes/mode, present pair (0,0)
//   step_i                advance to the next pair (ignored after the final one)
//   size_x_i, size_y_i    run lengths (only sampled with load_i)
//   mode_i                0 = convolution, 1 = correlation (Y read reversed)
//   addr_x_o, addr_y_o    read addresses for the current pair
//   valid_o               a pair is being presented this cycle
//   first_o, last_o       current pair is the first / last term of its n
//   final_o               current pair is the last of the run
//   n_o                   output index of the current pair
// ---------------------------------------------------------------------------
module conv_index_gen
  import conv_mac_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] size_x_i,
  input  logic [ADDR_WIDTH-1:0] size_y_i,
  input  logic                  mode_i,
  output logic [ADDR_WIDTH-1:0] addr_x_o,
  output logic [ADDR_WIDTH-1:0] addr_y_o,
  output logic                  valid_o,
  output logic                  first_o,
  output logic                  last_o,
  output logic                  final_o,
  output logic [ADDR_WIDTH:0]   n_o
);

  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [NW-1:0]         ONE_N = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0]         TWO_N = ONE_N + ONE_N;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Highest k for output n: min(n, size_x-1)
  function automatic logic [NW-1:0] k_hi(input logic [NW-1:0] n, input logic [NW-1:0] sx);
    logic [NW-1:0] top_k;
    top_k = sx - ONE_N;
    if (n < top_k) begin
      return n;
    end else begin
      return top_k;
    end
  endfunction

  // Lowest k for output n: max(0, n-size_y+1)
  function automatic logic [NW-1:0] k_lo(input logic [NW-1:0] n, input logic [NW-1:0] sy);
    if ((n + ONE_N) > sy) begin
      return n + ONE_N - sy;
    end else begin
      return {NW{1'b0}};
    end
  endfunction

  logic [ADDR_WIDTH-1:0] sx_q, sy_q;
  mode_t                 mode_q;
  logic [NW-1:0]         n_q, k_q;
  logic [ADDR_WIDTH-1:0] addr_x_q, addr_y_q;
  logic                  valid_q, first_q, last_q, final_q;

  logic [ADDR_WIDTH-1:0] sx_s, sy_s, j_s, y_d;
  mode_t                 mode_s;
  logic [NW-1:0]         sx_n, sy_n, n_d, k_d;
  logic                  first_d, last_d, final_d;

  // Next (n, k) pair, its tags and its Y address
  always_comb begin
    // On load the latched sizes are not yet valid, so use the inputs directly
    sx_s   = load_i ? size_x_i : sx_q;
    sy_s   = load_i ? size_y_i : sy_q;
    mode_s = load_i ? mode_t'(mode_i) : mode_q;
    sx_n   = {1'b0, sx_s};
    sy_n   = {1'b0, sy_s};
    n_d    = n_q;
    k_d    = k_q;
    if (load_i) begin
      n_d = {NW{1'b0}};
      k_d = {NW{1'b0}};
    end else if (k_q == k_hi(n_q, sx_n)) begin
      n_d = n_q + ONE_N;
      k_d = k_lo(n_q + ONE_N, sy_n);
    end else begin
      n_d = n_q;
      k_d = k_q + ONE_N;
    end
    first_d = (k_d == k_lo(n_d, sy_n));
    last_d  = (k_d == k_hi(n_d, sx_n));
    final_d = last_d && (n_d == (sx_n + sy_n - TWO_N));
    // n-k is always < size_y, so modulo-2^ADDR_WIDTH arithmetic is exact
    j_s = n_d[ADDR_WIDTH-1:0] - k_d[ADDR_WIDTH-1:0];
    if (mode_s == MODE_CORR) begin
      y_d = sy_s - ONE_A - j_s;
    end else begin
      y_d = j_s;
    end
  end

  // Pair registers; addresses hold their last value once the run ends
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q     <= {ADDR_WIDTH{1'b0}};
      sy_q     <= {ADDR_WIDTH{1'b0}};
      mode_q   <= MODE_CONV;
      n_q      <= {NW{1'b0}};
      k_q      <= {NW{1'b0}};
      addr_x_q <= {ADDR_WIDTH{1'b0}};
      addr_y_q <= {ADDR_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      final_q  <= 1'b0;
    end else begin
      if (load_i) begin
        sx_q   <= size_x_i;
        sy_q   <= size_y_i;
        mode_q <= mode_t'(mode_i);
      end
      if (load_i || (step_i && !final_q)) begin
        n_q      <= n_d;
        k_q      <= k_d;
        addr_x_q <= k_d[ADDR_WIDTH-1:0];
        addr_y_q <= y_d;
        valid_q  <= 1'b1;
        first_q  <= first_d;
        last_q   <= last_d;
        final_q  <= final_d;
      end else if (step_i) begin
        valid_q <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
        final_q <= 1'b0;
      end
    end
  end

  assign addr_x_o = addr_x_q;
  assign addr_y_o = addr_y_q;
  assign valid_o  = valid_q;
  assign first_o  = first_q;
  assign last_o   = last_q;
  assign final_o  = final_q;
  assign n_o      = n_q;

endmodule

// File: rtl/conv_mac_engine.sv
// ---------------------------------------------------------------------------
// conv_mac_engine
// Signed 1-D convolution / correlation engine: Z[n] = sum_k X[k]*Y[n-k]
// (correlation reads Y at size_y-1-(n-k)). One MAC per cycle; every Z sample
// is written to the result memory in ascending n order.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (aborts a run)
//   bus   conv_mac_engine_if.slave: start/size_x/size_y/mode, X/Y read ports,
//         Z write port (dataz/memz_addr/writez), busy, done
// Build option:
//   CONV_MAC_SATURATE_EN  clamp dataz to the OUT_WIDTH signed range and add a
//                         sticky bus.sat_flag; otherwise dataz is truncated.
// Timing (start in cycle 0, P = size_x*size_y): addresses in cycles 1..P,
// last writez in cycle P+2, done in cycle P+3.
// ---------------------------------------------------------------------------
module conv_mac_engine
  import conv_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  conv_mac_engine_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;
  localparam logic [1:0] DRAIN_LAST = 2'(PIPE_DEPTH - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       start_ok_s, zero_size_s, load_s, step_s;

  logic [ADDR_WIDTH-1:0] idx_x_s, idx_y_s;
  logic                  idx_valid_s, idx_first_s, idx_last_s, idx_final_s;
  logic [ADDR_WIDTH:0]   idx_n_s;

  // Tags aligned with the cycle the read data returns
  logic                  s1_valid_q, s1_first_q, s1_last_q;
  logic [ADDR_WIDTH:0]   s1_n_q;

  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]    prod_ext_s;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;

  logic [OUT_WIDTH-1:0]  dataz_q, dataz_d;
  logic [ADDR_WIDTH:0]   memz_addr_q;
  logic                  writez_q, busy_q, done_q;

  assign start_ok_s  = (state_q == S_IDLE) && bus.start;
  assign zero_size_s = (bus.size_x == {ADDR_WIDTH{1'b0}}) || (bus.size_y == {ADDR_WIDTH{1'b0}});
  assign load_s      = start_ok_s && !zero_size_s;
  assign step_s      = (state_q == S_RUN);

  conv_index_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_index_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_s),
    .step_i   (step_s),
    .size_x_i (bus.size_x),
    .size_y_i (bus.size_y),
    .mode_i   (bus.mode),
    .addr_x_o (idx_x_s),
    .addr_y_o (idx_y_s),
    .valid_o  (idx_valid_s),
    .first_o  (idx_first_s),
    .last_o   (idx_last_s),
    .final_o  (idx_final_s),
    .n_o      (idx_n_s)
  );

  // Control FSM next state
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          state_d = zero_size_s ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (idx_final_s) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign prod_s     = $signed(bus.datax) * $signed(bus.datay);
  assign prod_ext_s = ACC_WIDTH'(prod_s);

  // Accumulate; the first term of each n restarts the sum
  always_comb begin
    if (s1_first_q) begin
      acc_d = prod_ext_s;
    end else begin
      acc_d = acc_q + prod_ext_s;
    end
  end

`ifdef CONV_MAC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic sat_hit_s, sat_q;

  // Clamp the accumulator into the signed output range
  always_comb begin
    if (acc_d > OUT_MAX) begin
      dataz_d   = OUT_MAX[OUT_WIDTH-1:0];
      sat_hit_s = 1'b1;
    end else if (acc_d < OUT_MIN) begin
      dataz_d   = OUT_MIN[OUT_WIDTH-1:0];
      sat_hit_s = 1'b1;
    end else begin
      dataz_d   = acc_d[OUT_WIDTH-1:0];
      sat_hit_s = 1'b0;
    end
  end

  // Sticky clamp flag, cleared by every accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (start_ok_s) begin
      sat_q <= 1'b0;
    end else if (s1_valid_q && s1_last_q && sat_hit_s) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  // Two's-complement truncation to the output width
  always_comb begin
    dataz_d = acc_d[OUT_WIDTH-1:0];
  end
`endif

  // FSM state, pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 2'd0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_n_q      <= {(ADDR_WIDTH+1){1'b0}};
      acc_q       <= {ACC_WIDTH{1'b0}};
      writez_q    <= 1'b0;
      dataz_q     <= {OUT_WIDTH{1'b0}};
      memz_addr_q <= {(ADDR_WIDTH+1){1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      s1_valid_q  <= idx_valid_s;
      s1_first_q  <= idx_first_s;
      s1_last_q   <= idx_last_s;
      s1_n_q      <= idx_n_s;
      if (s1_valid_q) begin
        acc_q <= acc_d;
      end
      writez_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q && s1_last_q) begin
        dataz_q     <= dataz_d;
        memz_addr_q <= s1_n_q;
      end
      busy_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q <= (state_d == S_DONE);
    end
  end

  assign bus.memx_addr = idx_x_s;
  assign bus.memy_addr = idx_y_s;
  assign bus.dataz     = dataz_q;
  assign bus.memz_addr = memz_addr_q;
  assign bus.writez    = writez_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
